// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: store CTL encodings, store buffer entry and alignment check.
package mips_mem_pkg;

  localparam logic [1:0] CTL_BYTE    = 2'd0;
  localparam logic [1:0] CTL_HALF    = 2'd1;
  localparam logic [1:0] CTL_WORD    = 2'd2;
  localparam logic [1:0] CTL_ILLEGAL = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  ctl;
    logic [31:0] pc;
  } stbuf_entry_t;

  // An illegal CTL is never aligned, so a single check covers both drop causes.
  function automatic logic is_aligned(input logic [31:0] addr, input logic [1:0] ctl);
    logic ok;
    unique case (ctl)
      CTL_BYTE: ok = 1'b1;
      CTL_HALF: ok = (addr[0] == 1'b0);
      CTL_WORD: ok = (addr[1:0] == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stbuf_match.sv
// Load word-address comparators over all store buffer entries, with youngest-match select.
module stbuf_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [29:0]      waddr [DEPTH],
  input  logic [DEPTH-1:0] is_word,
  input  logic [31:0]      wd    [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PTR_W-1:0] tail,
  input  logic             ld_valid,
  input  logic [29:0]      ld_waddr,
  output logic             hit,
  output logic             hit_word,
  output logic [31:0]      hit_wd
);

  logic [DEPTH-1:0] eq;
  logic [PTR_W-1:0] idx;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      eq[i] = ld_valid && valid[i] && (waddr[i] == ld_waddr);
    end
  end

  // Walk from tail-1 back toward head so the first hit is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_word = 1'b0;
    hit_wd   = '0;
    idx      = '0;
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      idx = tail - PTR_W'(i);
      if (!hit && eq[idx]) begin
        hit      = 1'b1;
        hit_word = is_word[idx];
        hit_wd   = wd[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM and data memory, drained in order one entry per cycle.
// Define STORE_BUFFER_FWD_EN to forward word data from the youngest matching word store.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wd,
  input  logic [1:0]       st_ctl,
  input  logic [31:0]      st_pc,
  output logic             st_ready,
  output logic             st_misalign,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hazard,
  output logic             ld_fwd_valid,
  output logic [31:0]      ld_fwd_data,
  input  logic             dm_busy,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  output logic [1:0]       dm_ctl,
  output logic [31:0]      dm_pc,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  stbuf_entry_t     entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             misalign_q;
  logic             push, pop, drop;
  stbuf_entry_t     head_entry;

  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign st_ready    = (count_q != FULL_CNT);
  assign st_misalign = misalign_q;
  assign dm_we       = !empty && !dm_busy;
  assign pop         = dm_we;
  assign push        = st_valid && st_ready && is_aligned(st_addr, st_ctl);
  assign drop        = st_valid && st_ready && !is_aligned(st_addr, st_ctl);

  assign head_entry = entry_q[head_q];
  assign dm_addr    = head_entry.addr;
  assign dm_wd      = head_entry.wd;
  assign dm_ctl     = head_entry.ctl;
  assign dm_pc      = head_entry.pc;

  always_comb begin
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      misalign_q <= drop;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
    end
  end

  // Entry payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[tail_q] <= '{addr: st_addr, wd: st_wd, ctl: st_ctl, pc: st_pc};
    end
  end

  logic [29:0]      m_waddr [DEPTH];
  logic [31:0]      m_wd    [DEPTH];
  logic [DEPTH-1:0] m_is_word;
  logic             hit, hit_word;
  logic [31:0]      hit_wd;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m_waddr[i]   = entry_q[i].addr[31:2];
      m_wd[i]      = entry_q[i].wd;
      m_is_word[i] = (entry_q[i].ctl == CTL_WORD);
    end
  end

  stbuf_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .waddr    (m_waddr),
    .is_word  (m_is_word),
    .wd       (m_wd),
    .valid    (valid_q),
    .tail     (tail_q),
    .ld_valid (ld_valid),
    .ld_waddr (ld_addr[31:2]),
    .hit      (hit),
    .hit_word (hit_word),
    .hit_wd   (hit_wd)
  );

  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];

`ifdef STORE_BUFFER_FWD_EN
  assign ld_fwd_valid = hit && hit_word;
  assign ld_hazard    = hit && !hit_word;
  assign ld_fwd_data  = ld_fwd_valid ? hit_wd : 32'd0;
`else
  logic unused_fwd;
  assign unused_fwd   = ^{hit_word, hit_wd};
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = 32'd0;
  assign ld_hazard    = hit;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (clr_n) begin
      assert (!(st_valid && ld_valid))
        else $error("store_buffer: st_valid and ld_valid asserted together");
    end
  end
`endif

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM pipeline stage and the data memory.
- Accepts byte, half and word stores from the pipeline in one cycle.
- Drains them in order to the data memory's WE/addr/WD/CTL/PC inputs, one per cycle.
- Flags loads that hit a pending store so the hazard unit can stall, and rejects misaligned or illegal stores.

Parameters:
- DEPTH, 4, number of buffer entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request from MEM stage
- st_addr  in  32  store byte address
- st_wd  in  32  store data; byte/half data in the low bits
- st_ctl  in  2  0=byte, 1=half, 2=word, 3=illegal
- st_pc  in  32  PC of the store instruction
- st_ready  out  1  buffer can accept a store this cycle
- st_misalign  out  1  one-cycle pulse: the store was dropped
- ld_valid  in  1  load in MEM stage
- ld_addr  in  32  load byte address
- ld_hazard  out  1  load word-address matches a pending entry
- ld_fwd_valid  out  1  forwarded data valid (optional feature)
- ld_fwd_data  out  32  forwarded word (optional feature)
- dm_busy  in  1  data memory cannot accept a write this cycle
- dm_we  out  1  write enable to data memory
- dm_addr  out  32  head entry address
- dm_wd  out  32  head entry data
- dm_ctl  out  2  head entry CTL
- dm_pc  out  32  head entry PC
- empty  out  1  no pending entries
- count  out  PTR_W+1  occupancy

Behaviour:
- Storage and reset
  - Circular FIFO of DEPTH entries, each {addr, wd, ctl, pc}, with head/tail pointers and count.
  - clr_n low asynchronously clears pointers, count, st_misalign and the valid bits; entry contents need not be cleared.
  - Reset values: empty=1, count=0, dm_we=0, st_ready=1, ld_hazard=0, ld_fwd_valid=0, ld_fwd_data=0.
  - Reset mid-drain discards all pending entries with no partial write.
- Acceptance
  - st_ready = (count != DEPTH).
  - A store is accepted when st_valid && st_ready && aligned && st_ctl != 3; it is written at tail and count increments.
  - Alignment: word needs addr[1:0]==0; half needs addr[0]==0; byte is always aligned.
  - A misaligned or ctl==3 store with st_valid && st_ready is not enqueued; st_misalign pulses high the next cycle.
  - st_valid while full: nothing enqueued and no flag; the pipeline must hold the request.
- Drain
  - dm_* outputs come straight from the head entry registers (registered, no combinational input-to-output path).
  - dm_we = !empty && !dm_busy.
  - On a clock edge with dm_we=1, head advances and count decrements.
  - Minimum latency from accept to dm_we is 1 cycle; an empty buffer never bypasses.
- Simultaneous push and pop
  - Both occur in the same cycle; count is unchanged.
  - When full, push is refused even if a pop occurs that cycle, because st_ready depends only on count.
- Pointers wrap modulo DEPTH.
- Ordering: drain order equals accept order.
- Load hazard
  - ld_hazard = ld_valid && any valid entry (head included) has addr[31:2] == ld_addr[31:2].
  - ld_hazard is purely combinational on registered state.
  - A store being accepted in the same cycle is not compared.
  - st_valid and ld_valid are never high together; simulation flags an error if they are.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- With the macro defined:
  - If the youngest matching entry is a word store (ctl==2), ld_fwd_valid=1, ld_fwd_data=that entry's wd, and ld_hazard=0.
  - Any other match, including a youngest byte or half store, gives ld_hazard=1 and ld_fwd_valid=0.
  - The youngest match is found by scanning from tail-1 toward head.
- Without the macro: ld_fwd_valid and ld_fwd_data are tied to 0, and every match raises ld_hazard.

Decomposition:
- Shared package mips_mem_pkg holds:
  - CTL_BYTE=2'd0, CTL_HALF=2'd1, CTL_WORD=2'd2, CTL_ILLEGAL=2'd3.
  - The stbuf_entry_t struct {addr, wd, ctl, pc}.
  - The alignment-check function, which is reused by the load path.
- One sub-module, stbuf_match: per-entry word-address comparators plus youngest-match priority select.
- FIFO storage and pointers stay in the top module.

Test Plan:
1. Reset, word store addr 0x10 data 0xDEADBEEF ctl 2 -> next cycle dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF; after the edge empty=1.
2. dm_busy=1, four stores to 0x0/0x4/0x8/0xC -> count=4, st_ready=0; fifth st_valid not enqueued; release dm_busy -> four writes in order, one per cycle.
3. Half store to 0x3 and word store to 0x6 -> st_misalign pulses each, count stays 0; ctl 3 to 0x0 -> also dropped and flagged.
4. Pending byte store to 0x21, load from 0x20 -> ld_hazard=1; load from 0x24 -> ld_hazard=0; after drain, load 0x20 -> ld_hazard=0.
5. Full buffer, assert clr_n low mid-cycle -> dm_we drops immediately, count=0; after release, no stale writes.
6. STORE_BUFFER_FWD_EN defined, word stores 0x11111111 then 0x22222222 to 0x40, load 0x40 -> ld_fwd_valid=1, ld_fwd_data=0x22222222, ld_hazard=0.
